// File: rtl/entry_token_issuer.sv
// Parking-gate entry controller: debounces the car sensor, issues a 3-bit LFSR token per car, and runs a timed session.
// Latency: filtered sensor rise to token_valid in 1 clock, request 1 clock later; no backpressure (done and tick are pulses).
module entry_token_issuer #(
  parameter int DEBOUNCE      = 4,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       car_sensor,
  input  logic       tick,
  input  logic       done,
  output logic       request,
  output logic [2:0] system_token,
  output logic [7:0] TimeData,
  output logic       token_valid,
  output logic       timeout
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ACTIVE,
    S_COOLDOWN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_timeout_exit;
  logic            w_to_hit;
  logic [2:0]      r_lfsr;
  logic [7:0]      r_time;
  logic            r_filt;
  logic [DW-1:0]   r_dcnt;
  logic [TW-1:0]   r_tcnt;
  logic            r_request;
  logic            r_token_valid;
  logic            r_timeout;
  logic [2:0]      r_token;

  // This tick is the one that would bring the session counter up to TIMEOUT_TICKS.
  assign w_to_hit = tick && (r_tcnt == TO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_timeout_exit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_filt) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        // done outranks a departing car, which outranks the timeout.
        if (done) begin
          w_next = S_COOLDOWN;
        end else if (!r_filt) begin
          w_next = S_COOLDOWN;
        end else if (w_to_hit) begin
          w_next         = S_COOLDOWN;
          w_timeout_exit = 1'b1;
        end
      end
      S_COOLDOWN: begin
        if (!r_filt) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_request     <= 1'b0;
      r_token_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_token       <= 3'b000;
    end else begin
      r_request     <= (w_next == S_ACTIVE);
      r_token_valid <= (w_next == S_ISSUE);
      r_timeout     <= w_timeout_exit;
      if ((r_state == S_IDLE) && (w_next == S_ISSUE)) begin
        r_token <= r_lfsr;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tcnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_tcnt <= '0;
    end else if ((r_state == S_ACTIVE) && tick) begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  // The filtered level only flips after DEBOUNCE consecutive disagreeing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_filt <= 1'b0;
      r_dcnt <= '0;
    end else if (car_sensor != r_filt) begin
      if (r_dcnt == DB_LAST) begin
        r_filt <= car_sensor;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end else begin
      r_dcnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lfsr <= 3'b001;
    end else begin
      r_lfsr <= {r_lfsr[1:0], r_lfsr[2] ^ r_lfsr[1]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_time <= 8'd0;
    end else if (tick) begin
      r_time <= r_time + 8'd1;
    end
  end

  assign request      = r_request;
  assign system_token = r_token;
  assign TimeData     = r_time;
  assign token_valid  = r_token_valid;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_entry_token_issuer.sv
// Directed bench for entry_token_issuer: glitch, normal session, timeout, simultaneous done/tick, wrap, async reset.
module tb_entry_token_issuer;

  logic       clock = 1'b0;
  logic       reset;
  logic       car_sensor;
  logic       tick;
  logic       done;
  logic       request;
  logic [2:0] system_token;
  logic [7:0] TimeData;
  logic       token_valid;
  logic       timeout;

  int tests = 0;
  int fails = 0;
  int ncyc;
  int tv_cnt = 0;
  int to_cnt = 0;
  logic [2:0] seq [7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
  logic [2:0] tok_held;

  entry_token_issuer #(.DEBOUNCE(4), .TIMEOUT_TICKS(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .car_sensor   (car_sensor),
    .tick         (tick),
    .done         (done),
    .request      (request),
    .system_token (system_token),
    .TimeData     (TimeData),
    .token_valid  (token_valid),
    .timeout      (timeout)
  );

  always #5 clock = ~clock;

  // Clock edges since the last reset release.
  always @(posedge clock or negedge reset) begin
    if (!reset) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  always @(negedge clock) begin
    if (token_valid === 1'b1) tv_cnt++;
    if (timeout === 1'b1)     to_cnt++;
  end

  // LFSR value held before the edge that entered ISSUE (edge number k).
  function automatic logic [2:0] lfsr_before(input int k);
    return seq[(k - 1) % 7];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks_in_active(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
    end
  endtask

  initial begin
    reset = 1'b0; car_sensor = 1'b0; tick = 1'b1; done = 1'b0;
    step(2);
    chk("rst_request", request, 0);
    chk("rst_token", system_token, 0);
    chk("rst_time", TimeData, 0);
    chk("rst_token_valid", token_valid, 0);
    chk("rst_timeout", timeout, 0);
    tick = 1'b0;
    #3 reset = 1'b1;
    step(1);

    // Glitch of 3 clocks is rejected.
    car_sensor = 1'b1;
    step(3);
    car_sensor = 1'b0;
    step(6);
    chk("glitch_no_token", tv_cnt, 0);
    chk("glitch_request", request, 0);

    // Normal session.
    car_sensor = 1'b1;
    step(4);
    chk("norm_tv_early", token_valid, 0);
    step(1);
    chk("norm_tv", token_valid, 1);
    chk("norm_token", system_token, lfsr_before(ncyc));
    chk("norm_req_during_issue", request, 0);
    tok_held = lfsr_before(ncyc);
    step(1);
    chk("norm_tv_drop", token_valid, 0);
    chk("norm_req_rise", request, 1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("norm_req_held", request, 1);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("norm_req_fall", request, 0);
    chk("norm_token_hold", system_token, tok_held);
    step(10);
    chk("cool_no_reissue", tv_cnt, 1);
    chk("cool_request", request, 0);
    car_sensor = 1'b0;
    step(6);
    chk("idle_token_hold", system_token, tok_held);
    chk("norm_time", TimeData, 0);

    // Timeout on the 16th tick.
    car_sensor = 1'b1;
    step(5);
    chk("to_tv", token_valid, 1);
    chk("to_token", system_token, lfsr_before(ncyc));
    step(1);
    chk("to_req_rise", request, 1);
    ticks_in_active(15);
    chk("to_req_before_16", request, 1);
    chk("to_no_early_timeout", to_cnt, 0);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("to_pulse", timeout, 1);
    chk("to_req_fall", request, 0);
    step(1);
    chk("to_pulse_end", timeout, 0);
    step(20);
    chk("to_no_reissue", tv_cnt, 2);
    chk("to_req_stays_low", request, 0);
    chk("to_time", TimeData, 16);
    car_sensor = 1'b0;
    step(6);

    // done together with the 16th tick: normal exit, no timeout.
    car_sensor = 1'b1;
    step(5);
    chk("sim_tv", token_valid, 1);
    step(1);
    chk("sim_req_rise", request, 1);
    ticks_in_active(15);
    tick = 1'b1; done = 1'b1;
    step(1);
    tick = 1'b0; done = 1'b0;
    chk("sim_req_fall", request, 0);
    chk("sim_no_timeout", timeout, 0);
    step(1);
    chk("sim_timeout_count", to_cnt, 1);
    car_sensor = 1'b0;
    step(6);
    chk("sim_time", TimeData, 32);

    // TimeData wrap.
    tick = 1'b1;
    step(223);
    chk("wrap_at_255", TimeData, 255);
    step(1);
    chk("wrap_to_0", TimeData, 0);
    step(255);
    chk("wrap_end_255", TimeData, 255);
    tick = 1'b0;
    step(2);

    // Async reset mid-ACTIVE.
    car_sensor = 1'b1;
    step(5);
    chk("ar_tv", token_valid, 1);
    step(1);
    chk("ar_req_rise", request, 1);
    #3 reset = 1'b0;
    #1;
    chk("ar_req_async", request, 0);
    chk("ar_token_async", system_token, 0);
    chk("ar_time_async", TimeData, 0);
    chk("ar_tv_async", token_valid, 0);
    #2 reset = 1'b1;
    step(4);
    chk("ar_rebounce_tv", token_valid, 0);
    chk("ar_rebounce_req", request, 0);
    step(1);
    chk("ar_reissue_tv", token_valid, 1);
    chk("ar_reissue_token", system_token, 3'b111);
    step(1);
    chk("ar_req_again", request, 1);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("ar_done_fall", request, 0);
    car_sensor = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
